// File: rtl/cfg_arb_pkg.sv
// rtl/cfg_arb_pkg.sv - shared types and default sizes for the config-space access arbiter
// Contents: arb_state_t (access sequencer states), default widths/timeout,
//           cfg_req_t (one latched access at default widths).
package cfg_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cfg_req_t;

endpackage

// File: rtl/cfg_access_arbiter_rr_arb2.sv
// rtl/cfg_access_arbiter_rr_arb2.sv - two-way round-robin winner select (combinational)
// Ports: valid[1:0] request lines, last_grant id of the previous grant,
//        winner id of the selected requester, any high when some request is valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any = |valid;
    // On a tie the requester that did not win last time goes next.
    if (valid == 2'b11) winner = ~last_grant;
    else                winner = valid[1];
  end

endmodule

// File: rtl/cfg_access_arbiter.sv
// rtl/cfg_access_arbiter.sv - shares the config-space access port between two requesters
// Ports: sb_clk/rst (async active-low) clock and reset;
//        reqN_valid/write/addr/wdata in, reqN_ready/done/rdata/err out (N = 0,1);
//        cs_read/cs_write strobes, cs_address/cs_wdata latched access, cs_rdata/cs_rvalid read return;
//        busy high whenever an access is in progress.
module cfg_access_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic              sb_clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              cs_read,
  output logic              cs_write,
  output logic [ADDR_W-1:0] cs_address,
  output logic [DATA_W-1:0] cs_wdata,
  input  logic [DATA_W-1:0] cs_rdata,
  input  logic              cs_rvalid,
  output logic              busy
);

  arb_state_t        state, next_state;
  logic              winner, any;
  logic              last_grant;
  logic              gid;
  logic              wr_lat;
  logic [CNT_W-1:0]  cnt;
  logic              timeout_hit;
  logic              resp_load;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  // Last waiting cycle: the counter has seen TIMEOUT-1 silent cycles already.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any) next_state = ISSUE;
      ISSUE:   next_state = wr_lat ? RESP : WAIT_RD;
      WAIT_RD: if (cs_rvalid || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && any && !winner;
    req1_ready = (state == IDLE) && any &&  winner;
    cs_read    = (state == ISSUE) && !wr_lat;
    cs_write   = (state == ISSUE) &&  wr_lat;
    req0_done  = (state == RESP) && !gid;
    req1_done  = (state == RESP) &&  gid;
    busy       = (state != IDLE);
  end

  // Result registered on entry to RESP so it is valid alongside done and then
  // held per requester. rvalid wins over the timeout in the same cycle.
  always_comb begin
    resp_load = ((state == ISSUE) && wr_lat) ||
                ((state == WAIT_RD) && (cs_rvalid || timeout_hit));
    resp_data = ((state == WAIT_RD) && cs_rvalid) ? cs_rdata : '0;
    resp_err  = (state == WAIT_RD) && !cs_rvalid;
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      gid        <= 1'b0;
      wr_lat     <= 1'b0;
      cs_address <= '0;
      cs_wdata   <= '0;
      cnt        <= '0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        gid        <= winner;
        wr_lat     <= winner ? req1_write : req0_write;
        cs_address <= winner ? req1_addr  : req0_addr;
        cs_wdata   <= winner ? req1_wdata : req0_wdata;
      end
      if (state == ISSUE)   cnt <= '0;
      if (state == WAIT_RD) cnt <= cnt + CNT_W'(1);
      if (state == RESP)    last_grant <= gid;
      if (resp_load) begin
        if (gid) begin
          req1_rdata <= resp_data;
          req1_err   <= resp_err;
        end else begin
          req0_rdata <= resp_data;
          req0_err   <= resp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_access_arbiter.sv
// tb/tb_cfg_access_arbiter.sv - self-checking bench for cfg_access_arbiter
module tb_cfg_access_arbiter;

  localparam int TO = 16;

  logic        sb_clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [7:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        cs_read, cs_write, cs_rvalid, busy;
  logic [7:0]  cs_address;
  logic [31:0] cs_wdata, cs_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state: who was granted last, and each requester's held result.
  int          lg_m;
  logic [31:0] held_rd [2];
  logic        held_err[2];

  always #5 sb_clk = ~sb_clk;

  cfg_access_arbiter dut (
    .sb_clk(sb_clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .cs_read(cs_read), .cs_write(cs_write), .cs_address(cs_address),
    .cs_wdata(cs_wdata), .cs_rdata(cs_rdata), .cs_rvalid(cs_rvalid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic chk_held();
    chk("rdata0_hold", req0_rdata, held_rd[0]);
    chk("rdata1_hold", req1_rdata, held_rd[1]);
    chk("err0_hold", req0_err, held_err[0]);
    chk("err1_hold", req1_err, held_err[1]);
  endtask

  // One access: request pattern applied in cycle 0, rvalid returned in cycle k
  // (k outside 2..TO+1 means config space stays silent and the read times out).
  task automatic run_access(input bit v0, input bit v1, input bit w0, input bit w1,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input int k, input bit stray);
    int          w, exp_done;
    bit          wr, tmo;
    logic [7:0]  ea;
    logic [31:0] ed, rv;
    step();
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
    cs_rvalid = 1'b0;
    #1;
    w = (v0 && v1) ? 1 - lg_m : (v1 ? 1 : 0);
    chk("ready0", req0_ready, w == 0);
    chk("ready1", req1_ready, w == 1);
    wr  = w ? w1 : w0;
    ea  = w ? a1 : a0;
    ed  = w ? d1 : d0;
    rv  = $urandom;
    tmo = !wr && !(k >= 2 && k <= TO + 1);
    exp_done = wr ? 2 : (tmo ? TO + 2 : k + 1);
    for (int c = 1; c <= exp_done; c++) begin
      step();
      // Fresh requests raised during the access must wait (and are dropped later).
      req0_valid = 1'($urandom); req0_addr = 8'($urandom); req0_wdata = $urandom;
      req1_valid = 1'($urandom); req1_addr = 8'($urandom); req1_wdata = $urandom;
      cs_rvalid  = (!wr && c == k) || (c == 1 && stray);
      cs_rdata   = (c == k) ? rv : $urandom;
      #1;
      if (c == 1) begin
        chk("cs_write", cs_write, wr);
        chk("cs_read", cs_read, !wr);
        chk("cs_address", cs_address, ea);
        chk("cs_wdata", cs_wdata, ed);
      end else begin
        chk("strobe_idle", {cs_read, cs_write}, 2'b00);
      end
      chk("ready_stall", {req1_ready, req0_ready}, 2'b00);
      chk("busy_active", busy, 1'b1);
      if (c == exp_done) begin
        held_rd[w]  = (wr || tmo) ? 32'h0 : rv;
        held_err[w] = tmo;
        chk("done", {req1_done, req0_done}, (w == 1) ? 2'b10 : 2'b01);
      end else begin
        chk("no_done", {req1_done, req0_done}, 2'b00);
      end
      chk_held();
    end
    lg_m = w;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cs_rvalid = stray;
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", {req1_done, req0_done}, 2'b00);
    chk_held();
    cs_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    cs_rdata = 0; cs_rvalid = 0;
    lg_m = 1;
    held_rd[0] = 0; held_rd[1] = 0; held_err[0] = 0; held_err[1] = 0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {cs_read, cs_write}, 2'b00);
    chk("rst_done", {req1_done, req0_done}, 2'b00);
    chk("rst_addr", cs_address, 8'h0);
    chk("rst_wdata", cs_wdata, 32'h0);
    chk_held();
    rst = 1'b1;

    // Single write, then a read answered 3 cycles after the strobe.
    run_access(1, 0, 1, 0, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0, 0, 0);
    run_access(0, 1, 0, 0, 8'h00, 8'h04, 32'h0, 32'h0, 4, 0);
    // Silent read times out, then a normal write from requester 1.
    run_access(1, 0, 0, 0, 8'h20, 8'h00, 32'h0, 32'h0, 999, 0);
    run_access(0, 1, 0, 1, 8'h00, 8'h30, 32'h0, 32'hCAFEF00D, 0, 0);
    // rvalid in the timeout cycle wins; one cycle later is too late.
    run_access(0, 1, 0, 0, 8'h00, 8'h31, 32'h0, 32'h0, TO + 1, 1);
    run_access(1, 0, 0, 0, 8'h32, 8'h00, 32'h0, 32'h0, TO + 2, 1);

    for (int i = 0; i < 30; i++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      run_access(v0, v1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                 $urandom, $urandom, $urandom_range(2, TO + 4), 1'($urandom));
    end

    // Reset while waiting for read data.
    step();
    req0_valid = 1; req0_write = 0; req0_addr = 8'h44;
    step();
    req0_valid = 0;
    repeat (2) step();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_strobes", {cs_read, cs_write}, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", {req1_done, req0_done}, 2'b00);
    held_rd[0] = 0; held_rd[1] = 0; held_err[0] = 0; held_err[1] = 0;
    lg_m = 1;
    chk_held();
    step();
    rst = 1'b1;

    // Both requesters pending for three accesses each: grants alternate from 0.
    for (int i = 0; i < 6; i++)
      run_access(1, 1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                 $urandom, $urandom, $urandom_range(2, 6), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_access_arbiter.md
Name: cfg_access_arbiter

Overview:
Shares the single logical-layer config-space access port between two requesters. Requester 0 is the sideband register-transaction handler; requester 1 is the local lane-initialisation FSM. The block arbitrates round-robin and sequences each access as issue, then wait, then respond. It enforces a read timeout so a silent config space cannot hang either requester. It sits between those two agents and the config-space register block, in the sideband clock domain.

Parameters:
ADDR_W, 8, config-space address width
DATA_W, 32, config-space data width
TIMEOUT, 16, maximum cycles to wait for cs_rvalid after a read issue; must be at least 2
CNT_W, 5, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
sb_clk  in  1  sideband clock; the only clock
rst  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has an access pending
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  access address
req0_wdata  in  DATA_W  write data
req0_ready  out  1  request accepted this cycle
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  DATA_W  read data, valid with req0_done
req0_err  out  1  timeout flag, valid with req0_done
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata, req1_err: identical to the req0 set, for requester 1
cs_read  out  1  one-cycle read strobe to config space
cs_write  out  1  one-cycle write strobe to config space
cs_address  out  ADDR_W  latched access address
cs_wdata  out  DATA_W  latched write data
cs_rdata  in  DATA_W  read data from config space
cs_rvalid  in  1  cs_rdata valid
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, sb_clk. Reset rst is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie.
- States:
  - IDLE
  - ISSUE
  - WAIT_RD
  - RESP
- IDLE:
  - Winner selection: if only one reqN_valid is high, that requester wins. If both are high, the requester not equal to last_grant wins.
  - reqN_ready is combinational and equals (state==IDLE and winner==N). At most one ready is high per cycle.
  - On acceptance: latch write/addr/wdata and the granted id; go to ISSUE.
  - A requester holds valid and its fields stable until it sees ready.
- ISSUE:
  - Drive cs_read or cs_write high for exactly this cycle. cs_address and cs_wdata are driven from the latches and held until the next acceptance.
  - A write goes to RESP.
  - A read clears the timeout counter and goes to WAIT_RD.
- WAIT_RD:
  - If cs_rvalid is high: capture cs_rdata, err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no rvalid: rdata=0, err=1, go to RESP.
  - cs_rvalid in the same cycle as the timeout takes precedence; the access succeeds.
- RESP:
  - The granted reqN_done pulses for exactly one cycle, with reqN_rdata and reqN_err valid in that cycle. Write completions return rdata=0 and err=0.
  - rdata and err hold their values until the next done pulse for that requester.
  - last_grant is set to the granted id; go to IDLE.
- Latency, with acceptance in cycle 0:
  - Write: strobe in cycle 1, done in cycle 2.
  - Read: strobe in cycle 1; rvalid in cycle k≥2 gives done in cycle k+1.
  - Timeout read: done in cycle TIMEOUT+2.
- Throughput: no acceptance occurs in RESP. Back-to-back writes therefore complete every 3 cycles.
- Stray cs_rvalid outside WAIT_RD is ignored.
- Requests are not interrupted: a valid raised during an active access waits. Deasserting valid before ready drops the request silently.
- Reset mid-operation returns to IDLE immediately. No done pulse is emitted and strobes drop asynchronously.

Decomposition:
- Shared package cfg_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} arb_state_t
  - the default ADDR_W, DATA_W and TIMEOUT constants
  - typedef struct cfg_req_t {write, addr, wdata}
- One sub-module is natural: rr_arb2, the two-way round-robin winner select (valid[1:0] and last_grant in; winner and any out), which is purely combinational.
- The FSM, latches and timeout counter stay in cfg_access_arbiter.

Test Plan:
1. Single write: req0 writes addr 0x10, data 0xDEADBEEF → req0_ready in cycle 0; cs_write=1, cs_address=0x10, cs_wdata=0xDEADBEEF in cycle 1; req0_done=1, err=0 in cycle 2.
2. Read with rvalid 3 cycles after the strobe: req1 reads 0x04, cs_rdata=0x12345678 → req1_done in cycle 5, rdata=0x12345678, err=0.
3. Simultaneous requests, both held for 3 accesses each → grants alternate 0,1,0,1,0,1 starting with 0 after reset; never two readies in one cycle.
4. Read with no rvalid, TIMEOUT=16 → req0_done in cycle 18 with err=1 and rdata=0; a following req1 write is accepted normally.
5. cs_rvalid in the timeout cycle → err=0 and data captured. A stray cs_rvalid while in IDLE → no done pulse.
6. rst asserted low during WAIT_RD → cs strobes, busy and done are all 0 immediately; after release, req0 wins a tie.
